// File: rtl/serial_twos_comp_n.sv
// Bit-serial two's-complement / pass-through unit, LSB first, zero latency, with stall and start resync.
// Optional overflow flag for the most-negative word when SERIAL_TC_OVF_EN is defined.
module serial_twos_comp_n #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          xin,
    input  logic          xin_valid,
    input  logic          start,
    input  logic          negate,
    output logic          yout,
    output logic          yout_valid,
    output logic [CW-1:0] bit_idx,
    output logic          frame_done
`ifdef SERIAL_TC_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {COPY = 1'b0, INVERT = 1'b1} st_t;

    st_t           st, st_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mode_q, mode_nxt;

    logic          e_first;
    logic [CW-1:0] e_cnt;
    st_t           e_st;
    logic          e_mode;
    logic          e_last;

    // Effective state for this cycle: start forces bit 0 of a fresh word
    always_comb begin
        e_first = start & xin_valid;
        e_cnt   = e_first ? '0 : cnt;
        e_st    = e_first ? COPY : st;
        e_mode  = (e_cnt == '0) ? negate : mode_q;
        e_last  = (e_cnt == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st     <= COPY;
            cnt    <= '0;
            mode_q <= 1'b1;
        end else begin
            st     <= st_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
        end
    end

    // Enter INVERT only after the first 1 has been copied out
    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        mode_nxt = mode_q;
        if (xin_valid) begin
            if (e_cnt == '0) begin
                mode_nxt = negate;
            end
            if (e_last) begin
                cnt_nxt = '0;
                st_nxt  = COPY;
            end else begin
                cnt_nxt = e_cnt + CW'(1);
                st_nxt  = ((e_st == INVERT) || (e_mode && xin)) ? INVERT : COPY;
            end
        end
    end

    // Mealy outputs, all held low while in reset
    always_comb begin
        yout       = 1'b0;
        yout_valid = 1'b0;
        bit_idx    = '0;
        frame_done = 1'b0;
`ifdef SERIAL_TC_OVF_EN
        ovf        = 1'b0;
`endif
        if (reset_n) begin
            yout       = xin_valid & (xin ^ (e_mode & (e_st == INVERT)));
            yout_valid = xin_valid;
            bit_idx    = e_cnt;
            frame_done = xin_valid & e_last;
`ifdef SERIAL_TC_OVF_EN
            ovf        = xin_valid & e_last & e_mode & (e_st == COPY) & xin;
`endif
        end
    end

endmodule

// File: tb/tb_serial_twos_comp_n.sv
// Directed bench for serial_twos_comp_n with WIDTH=4 and WIDTH=8 instances on shared stimulus.
module tb_serial_twos_comp_n;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       xin, xin_valid, start, negate;
    logic       y4, yv4, fd4;
    logic [1:0] idx4;
    logic       y8, yv8, fd8;
    logic [2:0] idx8;
`ifdef SERIAL_TC_OVF_EN
    logic       ovf4, ovf8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_twos_comp_n #(.WIDTH(4)) u4 (
        .clk(clk), .reset_n(reset_n), .xin(xin), .xin_valid(xin_valid),
        .start(start), .negate(negate), .yout(y4), .yout_valid(yv4),
        .bit_idx(idx4), .frame_done(fd4)
`ifdef SERIAL_TC_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_twos_comp_n #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(reset_n), .xin(xin), .xin_valid(xin_valid),
        .start(start), .negate(negate), .yout(y8), .yout_valid(yv8),
        .bit_idx(idx8), .frame_done(fd8)
`ifdef SERIAL_TC_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, let the Mealy outputs settle
    task automatic drive(input logic v, input logic s, input logic n, input logic x);
        xin_valid = v; start = s; negate = n; xin = x;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send a WIDTH=4 word LSB first and check each output bit against exp
    task automatic word4(input string tag, input logic [3:0] w, input logic n,
                         input logic s0, input logic [3:0] exp);
        logic [3:0] got;
        logic [3:0] fds;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0) ? s0 : 1'b0, n, w[i]);
            got[i] = y4;
            fds[i] = fd4;
            chk({tag, "_idx"}, 8'(idx4), 8'(i));
            tick();
        end
        chk({tag, "_y"}, 8'(got), 8'(exp));
        chk({tag, "_fd"}, 8'(fds), 8'h08);
    endtask

    task automatic word8(input string tag, input logic [7:0] w, input logic [7:0] exp,
                         input logic [7:0] exp_ovf);
        logic [7:0] got;
        logic [7:0] fds;
        logic [7:0] ovs;
        ovs = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i == 0), 1'b1, w[i]);
            got[i] = y8;
            fds[i] = fd8;
`ifdef SERIAL_TC_OVF_EN
            ovs[i] = ovf8;
`endif
            tick();
        end
        chk({tag, "_y"}, got, exp);
        chk({tag, "_fd"}, fds, 8'h80);
`ifdef SERIAL_TC_OVF_EN
        chk({tag, "_ovf"}, ovs, exp_ovf);
`else
        if (exp_ovf != ovs && exp_ovf == 8'hFF) chk({tag, "_ovf"}, ovs, exp_ovf);
`endif
    endtask

    initial begin
        logic [3:0] got;
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_y", 8'(y4), 8'h0);
        chk("rst_yv", 8'(yv4), 8'h0);
        chk("rst_fd", 8'(fd4), 8'h0);
        chk("rst_idx", 8'(idx4), 8'h0);
        tick();
        reset_n = 1'b1;
        #1;

        // 0110 -> 1010
        word4("neg6", 4'b0110, 1'b1, 1'b1, 4'b1010);

        // same word with a two-cycle stall between bits 1 and 2
        drive(1'b1, 1'b1, 1'b1, 1'b0); got[0] = y4; tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1); got[1] = y4; tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            chk("stall_yv", 8'(yv4), 8'h0);
            chk("stall_y", 8'(y4), 8'h0);
            chk("stall_idx", 8'(idx4), 8'h2);
            chk("stall_fd", 8'(fd4), 8'h0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1); got[2] = y4;
        chk("stall_fd2", 8'(fd4), 8'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0); got[3] = y4;
        chk("stall_fd3", 8'(fd4), 8'h1);
        tick();
        chk("stall_y", 8'(got), 8'b1010);

        // pass-through word then negated word, aligned without start
        word4("pass", 4'b1011, 1'b0, 1'b0, 4'b1011);
        word4("neg1", 4'b0001, 1'b1, 1'b0, 4'b1111);

        // abandon a word on its third bit
        drive(1'b1, 1'b1, 1'b1, 1'b0); chk("abort_fd0", 8'(fd4), 8'h0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0); chk("abort_fd1", 8'(fd4), 8'h0); tick();
        word4("resync", 4'b0001, 1'b1, 1'b1, 4'b1111);

        // 8-bit words
        word8("w80", 8'h80, 8'h80, 8'h80);
        word8("w00", 8'h00, 8'h00, 8'h00);
        word8("w05", 8'h05, 8'hFB, 8'h00);

        // reset in the middle of a word that is already inverting
        drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("pre_rst_y", 8'(y4), 8'h0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_y", 8'(y4), 8'h0);
        chk("mid_rst_yv", 8'(yv4), 8'h0);
        chk("mid_rst_idx", 8'(idx4), 8'h0);
        tick();
        reset_n = 1'b1;
        #1;
        word4("post_rst", 4'b0110, 1'b1, 1'b0, 4'b1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
